cacheline_adapter: RTL and testbench

- Sits directly below the cache, between its 256-bit line port (dfp_*) and the 64-bit burst memory (bmem_*).
- Turns each line read into one burst read request, then collects 4 returned beats into one line.
- Turns each line write into a 4-beat burst write.
- One transaction outstanding at a time; the result is returned to the cache with a single-cycle dfp_resp.

---
 rtl/cacheline_adapter_pkg.sv | 31 +++
 rtl/cacheline_adapter_if.sv | 41 ++++
 rtl/cacheline_adapter.sv | 145 ++++++++++++++
 tb/tb_cacheline_adapter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache-line / burst-memory adapter.
// Holds the beat geometry, the FSM state encoding and two small helpers:
// one for aligning addresses to a line, one for locating a beat inside a line.
package cacheline_adapter_types;

    localparam int BEATS       = 4;     // beats per cache line
    localparam int BEAT_W      = 64;    // burst data width
    localparam int LINE_W      = 256;   // cache line width, BEATS*BEAT_W
    localparam int OFFSET_BITS = 5;     // byte offset bits within a line
    localparam int ADDR_W      = 32;
    localparam int CNT_W       = 2;     // beat counter width, log2(BEATS)

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } adapter_state_t;

    // Clear the in-line byte offset so the address points at the line start.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Bit position of beat 'cnt' inside a line (cnt * 64).
    function automatic logic [7:0] beat_base(input logic [CNT_W-1:0] cnt);
        return {cnt, 6'd0};
    endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// Bundle of the cache-side line port (dfp_*) and the burst-memory port (bmem_*).
//   slave  : the adapter's view (takes line requests, drives the burst bus)
//   master : the environment's view (cache + memory side)
// dfp_addr/dfp_read/dfp_write/dfp_wdata : line request from the cache
// dfp_rdata/dfp_resp                    : line result back to the cache
// bmem_addr/bmem_read/bmem_write/bmem_wdata : burst request to memory
// bmem_ready/bmem_raddr/bmem_rdata/bmem_rvalid : memory handshake and read beats
interface cacheline_adapter_if;
    import cacheline_adapter_types::*;

    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

endinterface

// File: rtl/cacheline_adapter.sv
// Adapter between a 256-bit cache line port and a 64-bit burst memory.
// A line read becomes one burst read request followed by collection of four
// tagged beats; a line write becomes a four-beat burst write. Only one
// transaction is in flight; completion is a single-cycle dfp_resp.
// Ports:
//   clk : clock
//   rst : synchronous active-low reset
//   bus : cacheline_adapter_if.slave (dfp_* line port and bmem_* burst port)
// Every output is driven straight from a register; the registers are loaded
// from the next-state decode so outputs line up with the state they belong to.
module cacheline_adapter
    import cacheline_adapter_types::*;
(
    input  logic               clk,
    input  logic               rst,
    cacheline_adapter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_t    state_r;
    adapter_state_t    state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [LINE_W-1:0] buf_r;
    logic [LINE_W-1:0] buf_s;
    logic [LINE_W-1:0] rdata_r;
    logic [LINE_W-1:0] rdata_s;
    logic [BEAT_W-1:0] wdata_r;
    logic [BEAT_W-1:0] wdata_s;
    logic              resp_r;
    logic              read_r;
    logic              write_r;
    logic              raddr_hit_s;

    // Returning beats belong to us only when their tag names our line.
    assign raddr_hit_s = (bus.bmem_raddr[ADDR_W-1:OFFSET_BITS] == addr_r[ADDR_W-1:OFFSET_BITS]);

    // Next-state, counter, address, line buffer and output-data decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        buf_s   = buf_r;
        rdata_s = rdata_r;
        case (state_r)
            IDLE: begin
                addr_s = line_addr(bus.dfp_addr);
                // A simultaneous read+write is illegal; the write is served.
                if (bus.dfp_write) begin
                    state_s = WR_BURST;
                    buf_s   = bus.dfp_wdata;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (bus.dfp_read) begin
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (bus.bmem_ready) begin
                    state_s = RD_WAIT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (bus.bmem_rvalid && raddr_hit_s) begin
                    buf_s[beat_base(cnt_r) +: BEAT_W] = bus.bmem_rdata;
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_BEAT) begin
                        state_s = RESP;
                        // Publish the completed line together with dfp_resp.
                        rdata_s = buf_s;
                    end else begin
                        state_s = RD_WAIT;
                    end
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_BURST: begin
                // Only the first beat waits for bmem_ready; the rest stream out.
                if ((cnt_r == {CNT_W{1'b0}}) && !bus.bmem_ready) begin
                    state_s = WR_BURST;
                end else if (cnt_r == LAST_BEAT) begin
                    state_s = RESP;
                    cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_s = WR_BURST;
                    cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        if (state_s == WR_BURST) begin
            wdata_s = buf_s[beat_base(cnt_s) +: BEAT_W];
        end else begin
            wdata_s = {BEAT_W{1'b0}};
        end
    end

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            buf_r   <= {LINE_W{1'b0}};
            rdata_r <= {LINE_W{1'b0}};
            wdata_r <= {BEAT_W{1'b0}};
            resp_r  <= 1'b0;
            read_r  <= 1'b0;
            write_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            buf_r   <= buf_s;
            rdata_r <= rdata_s;
            wdata_r <= wdata_s;
            resp_r  <= (state_s == RESP);
            read_r  <= (state_s == RD_REQ);
            write_r <= (state_s == WR_BURST);
        end
    end

    assign bus.dfp_rdata  = rdata_r;
    assign bus.dfp_resp   = resp_r;
    assign bus.bmem_addr  = addr_r;
    assign bus.bmem_read  = read_r;
    assign bus.bmem_write = write_r;
    assign bus.bmem_wdata = wdata_r;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter. Inputs change on the
// falling edge; outputs are observed on the falling edge, half a cycle after
// the active rising edge.
module tb_cacheline_adapter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cacheline_adapter_if bus();

    cacheline_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks      = 0;
    int failures    = 0;
    int resp_cnt    = 0;
    int overlap_cnt = 0;
    logic [63:0]  wr_log[$];
    logic [255:0] l1, l2, l3, l4, l5, w1, w2, w3;

    // Advance one cycle and keep running tallies of resp pulses and overlaps.
    task automatic step();
        @(negedge clk);
        if (bus.dfp_resp === 1'b1) resp_cnt++;
        if (bus.bmem_read === 1'b1 && bus.bmem_write === 1'b1) overlap_cnt++;
    endtask

    task automatic idle_inputs();
        bus.dfp_addr    = 32'h0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = 256'h0;
        bus.bmem_ready  = 1'b1;
        bus.bmem_raddr  = 32'h0;
        bus.bmem_rdata  = 64'h0;
        bus.bmem_rvalid = 1'b0;
    endtask

    // Cache + memory side of one line read. Beats come from 'line'; gaps are
    // idle cycles before beats 1..3; a stray-tagged beat precedes beat
    // 'stray_before' (-1 for none); memory is not ready for 'stall' cycles.
    task automatic read_txn(input logic [31:0] addr, input logic [255:0] line,
                            input int gap1, input int gap2, input int gap3,
                            input int stray_before, input int stall,
                            output int req_start, output int req_cycles,
                            output bit addr_ok, output int resp_delay,
                            output logic [255:0] got_line);
        logic [31:0] la;
        int gaps[4];
        la = {addr[31:5], 5'b00000};
        gaps[0] = 0; gaps[1] = gap1; gaps[2] = gap2; gaps[3] = gap3;
        req_start = -1; req_cycles = 0; addr_ok = 1'b1; resp_delay = -1; got_line = 256'h0;
        bus.dfp_addr   = addr;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = (stall == 0);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.bmem_read === 1'b1) begin
                if (req_start < 0) req_start = i;
                req_cycles++;
                if (bus.bmem_addr !== la) addr_ok = 1'b0;
                if (req_cycles >= stall) bus.bmem_ready = 1'b1;
            end else if (req_cycles > 0) begin
                break;
            end
        end
        for (int k = 0; k < 4; k++) begin
            repeat (gaps[k]) step();
            if (k == stray_before) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr  = 32'hDEAD_0000;
                bus.bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                step();
            end
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = la;
            bus.bmem_rdata  = line[64*k +: 64];
            step();
            bus.bmem_rvalid = 1'b0;
            bus.bmem_raddr  = 32'h0;
            bus.bmem_rdata  = 64'h0;
        end
        for (int i = 1; i <= 20; i++) begin
            if (bus.dfp_resp === 1'b1) begin
                resp_delay = i;
                got_line   = bus.dfp_rdata;
                break;
            end
            step();
        end
        bus.dfp_read   = 1'b0;
        bus.bmem_ready = 1'b1;
    endtask

    // Cache + memory side of one line write; logs bmem_wdata on each write cycle.
    // Returns at the falling edge where dfp_resp is seen (resp_cycle, 1-based).
    task automatic write_txn(input logic [31:0] addr, input logic [255:0] data,
                             input int stall, output int resp_cycle, output bit addr_ok);
        logic [31:0] la;
        int hold;
        la = {addr[31:5], 5'b00000};
        wr_log.delete();
        resp_cycle = -1; addr_ok = 1'b1; hold = 0;
        bus.dfp_addr   = addr;
        bus.dfp_write  = 1'b1;
        bus.dfp_wdata  = data;
        bus.bmem_ready = (stall == 0);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.bmem_write === 1'b1) begin
                wr_log.push_back(bus.bmem_wdata);
                if (bus.bmem_addr !== la) addr_ok = 1'b0;
                hold++;
                if (hold >= stall) bus.bmem_ready = 1'b1;
            end
            if (bus.dfp_resp === 1'b1) begin
                resp_cycle = i;
                break;
            end
        end
        bus.dfp_write  = 1'b0;
        bus.bmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (bus.dfp_resp !== 1'b0) begin failures++; $display("FAIL rst_resp: got %b expected 0", bus.dfp_resp); end
        checks++; if (bus.bmem_read !== 1'b0) begin failures++; $display("FAIL rst_read: got %b expected 0", bus.bmem_read); end
        checks++; if (bus.bmem_write !== 1'b0) begin failures++; $display("FAIL rst_write: got %b expected 0", bus.bmem_write); end
        checks++; if (bus.bmem_wdata !== 64'h0) begin failures++; $display("FAIL rst_wdata: got %h expected 0", bus.bmem_wdata); end
        checks++; if (bus.bmem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", bus.bmem_addr); end
        checks++; if (bus.dfp_rdata !== 256'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", bus.dfp_rdata); end
        rst = 1'b1;
        step();
        checks++; if (bus.bmem_read !== 1'b0 || bus.dfp_resp !== 1'b0) begin failures++; $display("FAIL idle_quiet: got read=%b resp=%b expected 0 0", bus.bmem_read, bus.dfp_resp); end
    endtask

    task automatic test_read_no_gaps();
        int rs, rc, rd, r0;
        bit ok;
        logic [255:0] gl;
        r0 = resp_cnt;
        read_txn(32'h0000_1234, l1, 0, 0, 0, -1, 0, rs, rc, ok, rd, gl);
        checks++; if (rs !== 1) begin failures++; $display("FAIL rd_req_start: got %0d expected 1", rs); end
        checks++; if (rc !== 1) begin failures++; $display("FAIL rd_req_cycles: got %0d expected 1", rc); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rd_addr: got mismatch expected 00001220"); end
        checks++; if (rd !== 1) begin failures++; $display("FAIL rd_latency: got %0d expected 1", rd); end
        checks++; if (gl !== l1) begin failures++; $display("FAIL rd_line: got %h expected %h", gl, l1); end
        step(); step();
        checks++; if (resp_cnt - r0 !== 1) begin failures++; $display("FAIL rd_resp_count: got %0d expected 1", resp_cnt - r0); end
        checks++; if (bus.dfp_rdata !== l1) begin failures++; $display("FAIL rd_hold: got %h expected %h", bus.dfp_rdata, l1); end
    endtask

    task automatic test_read_gaps();
        int rs, rc, rd, r0;
        bit ok;
        logic [255:0] gl;
        r0 = resp_cnt;
        read_txn(32'h0000_2A5F, l2, 0, 2, 1, 2, 0, rs, rc, ok, rd, gl);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL gap_addr: got mismatch expected 00002a40"); end
        checks++; if (rd !== 1) begin failures++; $display("FAIL gap_latency: got %0d expected 1", rd); end
        checks++; if (gl !== l2) begin failures++; $display("FAIL gap_line: got %h expected %h", gl, l2); end
        step(); step();
        checks++; if (resp_cnt - r0 !== 1) begin failures++; $display("FAIL gap_resp_count: got %0d expected 1", resp_cnt - r0); end
    endtask

    task automatic test_write();
        int rc;
        bit ok;
        write_txn(32'h8000_0040, w1, 0, rc, ok);
        checks++; if (bus.dfp_rdata !== l2) begin failures++; $display("FAIL wr_rdata_hold: got %h expected %h", bus.dfp_rdata, l2); end
        checks++; if (rc !== 5) begin failures++; $display("FAIL wr_latency: got %0d expected 5", rc); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_addr: got mismatch expected 80000040"); end
        checks++; if (wr_log.size() !== 4) begin failures++; $display("FAIL wr_beats: got %0d expected 4", wr_log.size()); end
        while (wr_log.size() < 4) wr_log.push_back(64'hx);
        checks++; if (wr_log[0] !== 64'hFEDC_BA98_7654_CDEF) begin failures++; $display("FAIL wr_beat0: got %h expected fedcba987654cdef", wr_log[0]); end
        checks++; if (wr_log[1] !== 64'h8899_AABB_CCDD_EEFF) begin failures++; $display("FAIL wr_beat1: got %h expected 8899aabbccddeeff", wr_log[1]); end
        checks++; if (wr_log[2] !== 64'h0011_2233_4455_6677) begin failures++; $display("FAIL wr_beat2: got %h expected 0011223344556677", wr_log[2]); end
        checks++; if (wr_log[3] !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL wr_beat3: got %h expected 0123456789abcdef", wr_log[3]); end
        step();
        checks++; if (bus.dfp_resp !== 1'b0 || bus.bmem_write !== 1'b0) begin failures++; $display("FAIL wr_done: got resp=%b write=%b expected 0 0", bus.dfp_resp, bus.bmem_write); end
    endtask

    task automatic test_read_stall();
        int rs, rc, rd;
        bit ok;
        logic [255:0] gl;
        read_txn(32'h0000_4460, l3, 1, 0, 0, -1, 6, rs, rc, ok, rd, gl);
        checks++; if (rc !== 6) begin failures++; $display("FAIL rstall_cycles: got %0d expected 6", rc); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstall_addr: got mismatch expected 00004460"); end
        checks++; if (rd !== 1) begin failures++; $display("FAIL rstall_latency: got %0d expected 1", rd); end
        checks++; if (gl !== l3) begin failures++; $display("FAIL rstall_line: got %h expected %h", gl, l3); end
        step();
    endtask

    task automatic test_write_stall();
        int rc, held;
        bit ok;
        write_txn(32'h0000_7790, w2, 6, rc, ok);
        checks++; if (rc !== 10) begin failures++; $display("FAIL wstall_latency: got %0d expected 10", rc); end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wstall_addr: got mismatch expected 00007780"); end
        checks++; if (wr_log.size() !== 9) begin failures++; $display("FAIL wstall_cycles: got %0d expected 9", wr_log.size()); end
        while (wr_log.size() < 9) wr_log.push_back(64'hx);
        held = 0;
        for (int i = 0; i < 6; i++) if (wr_log[i] === w2[63:0]) held++;
        checks++; if (held !== 6) begin failures++; $display("FAIL wstall_hold: got %0d stable beat0 cycles expected 6", held); end
        checks++; if (wr_log[6] !== w2[127:64]) begin failures++; $display("FAIL wstall_beat1: got %h expected %h", wr_log[6], w2[127:64]); end
        checks++; if (wr_log[7] !== w2[191:128]) begin failures++; $display("FAIL wstall_beat2: got %h expected %h", wr_log[7], w2[191:128]); end
        checks++; if (wr_log[8] !== w2[255:192]) begin failures++; $display("FAIL wstall_beat3: got %h expected %h", wr_log[8], w2[255:192]); end
        step();
    endtask

    task automatic test_back_to_back();
        int wc, rs, rc, rd, r0, o0;
        bit wok, rok;
        logic [255:0] gl;
        r0 = resp_cnt;
        o0 = overlap_cnt;
        write_txn(32'h0000_0100, w3, 0, wc, wok);
        read_txn(32'h0000_0200, l4, 0, 0, 0, -1, 0, rs, rc, rok, rd, gl);
        checks++; if (wc !== 5) begin failures++; $display("FAIL evict_wr_latency: got %0d expected 5", wc); end
        checks++; if (rs !== 2) begin failures++; $display("FAIL evict_rd_start: got %0d expected 2", rs); end
        checks++; if (rok !== 1'b1 || wok !== 1'b1) begin failures++; $display("FAIL evict_addr: got wr_ok=%b rd_ok=%b expected 1 1", wok, rok); end
        checks++; if (gl !== l4) begin failures++; $display("FAIL evict_line: got %h expected %h", gl, l4); end
        step(); step();
        checks++; if (resp_cnt - r0 !== 2) begin failures++; $display("FAIL evict_resp_count: got %0d expected 2", resp_cnt - r0); end
        checks++; if (overlap_cnt - o0 !== 0) begin failures++; $display("FAIL evict_overlap: got %0d expected 0", overlap_cnt - o0); end
    endtask

    task automatic test_reset_mid_burst();
        int rs, rc, rd, r0;
        bit ok;
        logic [255:0] gl;
        bus.dfp_addr   = 32'h0000_0300;
        bus.dfp_write  = 1'b1;
        bus.dfp_wdata  = w1;
        bus.bmem_ready = 1'b1;
        step(); step(); step();
        checks++; if (bus.bmem_write !== 1'b1 || bus.bmem_wdata !== w1[191:128]) begin failures++; $display("FAIL mid_beat2: got write=%b data=%h expected 1 %h", bus.bmem_write, bus.bmem_wdata, w1[191:128]); end
        rst = 1'b0;
        bus.dfp_write = 1'b0;
        r0 = resp_cnt;
        step();
        checks++; if (bus.bmem_write !== 1'b0 || bus.bmem_read !== 1'b0 || bus.dfp_resp !== 1'b0) begin failures++; $display("FAIL mid_rst_ctrl: got write=%b read=%b resp=%b expected 0 0 0", bus.bmem_write, bus.bmem_read, bus.dfp_resp); end
        checks++; if (bus.bmem_wdata !== 64'h0 || bus.bmem_addr !== 32'h0) begin failures++; $display("FAIL mid_rst_bus: got wdata=%h addr=%h expected 0 0", bus.bmem_wdata, bus.bmem_addr); end
        checks++; if (bus.dfp_rdata !== 256'h0) begin failures++; $display("FAIL mid_rst_rdata: got %h expected 0", bus.dfp_rdata); end
        rst = 1'b1;
        repeat (4) step();
        checks++; if (resp_cnt !== r0) begin failures++; $display("FAIL mid_no_resp: got %0d pulses expected 0", resp_cnt - r0); end
        read_txn(32'h0000_0560, l5, 0, 0, 0, -1, 0, rs, rc, ok, rd, gl);
        checks++; if (rs !== 1 || rc !== 1) begin failures++; $display("FAIL mid_rd_req: got start=%0d cycles=%0d expected 1 1", rs, rc); end
        checks++; if (rd !== 1 || gl !== l5) begin failures++; $display("FAIL mid_rd_line: got delay=%0d line=%h expected 1 %h", rd, gl, l5); end
    endtask

    initial begin
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l2 = {64'hD0D1_D2D3_D4D5_D6D7, 64'hC0C1_C2C3_C4C5_C6C7, 64'hB0B1_B2B3_B4B5_B6B7, 64'hA0A1_A2A3_A4A5_A6A7};
        l3 = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
        l4 = {64'h1357_9BDF_2468_ACE0, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'hCAFE_F00D_BEEF_0042};
        l5 = {64'h7777_0000_7777_0000, 64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000, 64'h4444_0000_4444_0000};
        w1 = {64'h0123_4567_89AB_CDEF, 64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF, 64'hFEDC_BA98_7654_CDEF};
        w2 = {64'h3030_3030_3030_3030, 64'h2020_2020_2020_2020, 64'h1010_1010_1010_1010, 64'h0A0B_0C0D_0E0F_1011};
        w3 = {64'hEEEE_DDDD_CCCC_BBBB, 64'hAAAA_9999_8888_7777, 64'h6666_5555_4444_3333, 64'h2222_1111_0000_FFFF};
        test_reset();
        test_read_no_gaps();
        test_read_gaps();
        test_write();
        test_read_stall();
        test_write_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within 1ms");
        $fatal(1, "timeout");
    end

endmodule
